// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the HI/LO multiply-divide unit: registered command pulses,
// shadow busy countdown and ID stall. Optional busy cross-check under MD_BUSY_CHECK_EN.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_md,
  input  logic [1:0]       id_md_op,
  input  logic             id_mt,
  input  logic             id_mf,
  input  logic             id_hl_sel,
  input  logic             ext_stall,
  input  logic             id_flush,
  input  logic [2:0]       md_busy,
`ifdef MD_BUSY_CHECK_EN
  output logic             md_err,
`endif
  output logic [3:0]       md_ctrl,
  output logic             md_we_hi,
  output logic             md_we_lo,
  output logic             md_stall,
  output logic [CNT_W-1:0] md_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic             uses, advance, issue_md, issue_mt;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       ctrl_d;
  logic             we_hi_d, we_lo_d;

  assign uses     = id_valid & (id_md | id_mt | id_mf);
  assign md_stall = uses & (md_cnt != '0);
  assign advance  = id_valid & ~md_stall & ~ext_stall & ~id_flush;
  // id_md wins over id_mt when the decoder raises both
  assign issue_md = advance & id_md;
  assign issue_mt = advance & ~id_md & id_mt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      md_cnt   <= '0;
      md_ctrl  <= 4'b0000;
      md_we_hi <= 1'b0;
      md_we_lo <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt   <= cnt_d;
      md_ctrl  <= ctrl_d;
      md_we_hi <= we_hi_d;
      md_we_lo <= we_lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = md_cnt;
    ctrl_d  = 4'b0000;
    we_hi_d = 1'b0;
    we_lo_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_md) begin
          ctrl_d  = {2'b10, id_md_op};
          cnt_d   = id_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_d = BUSY;
        end else if (issue_mt) begin
          we_hi_d = id_hl_sel;
          we_lo_d = ~id_hl_sel;
        end
      end
      BUSY: begin
        // the stall keeps md/mt ops out of ID, so the count only drains here
        cnt_d = md_cnt - 1'b1;
        if (md_cnt == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MD_BUSY_CHECK_EN
  // the unit may lag the shadow by one edge right after an issue, so skip that cycle
  always_ff @(posedge clk) begin
    if (!reset)
      md_err <= 1'b0;
    else if ((md_cnt == '0) && (md_busy != 3'd0) && !md_ctrl[3])
      md_err <= 1'b1;
  end
`else
  logic md_busy_unused;
  assign md_busy_unused = ^md_busy;
`endif

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Pipeline-side issue and hazard controller for the multiply/divide unit; sits between the ID-stage decoder and the HI/LO mul/div unit in EX.
- Turns decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO into one-cycle registered commands for the unit.
- Keeps a shadow busy countdown and stalls ID while the unit is still computing.
- Supplies the 4-bit ALUctr operation code the unit consumes.

Parameters:
- MUL_LAT, 5, busy cycles after a MULT/MULTU issue.
- DIV_LAT, 10, busy cycles after a DIV/DIVU issue.
- CNT_W, 4, shadow counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_md  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- id_md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- id_mt  in  1  ID instruction is MTHI/MTLO.
- id_mf  in  1  ID instruction is MFHI/MFLO.
- id_hl_sel  in  1  1=HI, 0=LO for mt/mf.
- ext_stall  in  1  stall requested by other hazard logic.
- id_flush  in  1  kill the ID instruction this cycle.
- md_busy  in  3  busy count reported by the mul/div unit.
- md_ctrl  out  4  ALUctr to unit: 1000 MUL, 1001 MULU, 1010 DIV, 1011 DIVU, 0000 none.
- md_we_hi  out  1  one-cycle HI write strobe (MTHI).
- md_we_lo  out  1  one-cycle LO write strobe (MTLO).
- md_stall  out  1  combinational ID stall request.
- md_cnt  out  CNT_W  shadow busy count, for debug.

Behaviour:
- Reset (reset==0 at a clk edge): md_ctrl=0000, md_we_hi=0, md_we_lo=0, md_cnt=0, FSM=IDLE. md_stall=0 because md_cnt=0.
- uses = id_valid & (id_md | id_mt | id_mf).
- md_stall = uses & (md_cnt != 0). It is combinational and does not depend on ext_stall.
- advance = id_valid & !md_stall & !ext_stall & !id_flush.
- md_ctrl, md_we_hi and md_we_lo are registered and default to 0 every cycle, so each issue is a single-cycle pulse.

Issue rules, applied at an edge where advance=1:
- id_md: md_ctrl <= {2'b10, id_md_op}. md_cnt <= MUL_LAT for op 00/01, DIV_LAT for op 10/11.
- id_mt: md_we_hi <= id_hl_sel; md_we_lo <= !id_hl_sel. md_cnt is unchanged.
- id_mf: nothing is issued; the op only had to wait out md_cnt.

Counter:
- When no issue occurs and md_cnt != 0, md_cnt decrements by 1 each cycle, including during ext_stall.
- md_cnt saturates at 0.

FSM (state is derived from md_cnt):
- IDLE (md_cnt=0) -> BUSY on an md issue.
- BUSY -> BUSY while md_cnt > 1.
- BUSY -> IDLE when md_cnt goes 1 -> 0.
- No new md op can issue in BUSY, because md_stall blocks it.

Boundary cases:
- md_cnt==1 with an md op in ID: stalls this cycle, issues next cycle, so back-to-back MULTs are spaced MUL_LAT+1 cycles apart.
- id_flush and ext_stall together: no issue, no strobes.
- Reset mid-operation clears md_cnt immediately; the next cycle has no stall.
- Multiple decode flags set at once is illegal; priority is id_md > id_mt > id_mf.

Optional Feature:
- Macro: MD_BUSY_CHECK_EN.
- Defined: adds output md_err (1 bit, reset 0, sticky). md_err is set at any edge where md_cnt == 0 and md_busy != 0 while not in the cycle directly after an issue (shadow says idle but unit is busy). It is cleared only by reset.
- Undefined: no md_err port and no checking logic.

Test Plan:
- Reset held low 2 cycles with id_md=1 -> md_ctrl=0000, md_cnt=0, md_stall=0. After release, first advance gives md_ctrl=1000 for exactly 1 cycle and md_cnt=5.
- MULT issued, then MFLO in ID next cycle -> md_stall=1 for exactly 5 cycles (md_cnt 5,4,3,2,1). MFLO advances when md_cnt=0.
- DIVU (op 11) then DIV back-to-back -> md_ctrl=1011, then 10 stall cycles, then md_ctrl=1010 and md_cnt=10.
- MTHI with id_hl_sel=1 while idle -> md_we_hi=1 and md_we_lo=0 for one cycle, md_cnt stays 0. MTLO gives md_we_lo=1 only.
- MULTU with ext_stall=1 for 3 cycles, then id_flush=1 -> no md_ctrl pulse throughout. An earlier in-flight md_cnt=4 still reaches 0 after 4 cycles.
- With MD_BUSY_CHECK_EN: force md_busy=3 while md_cnt=0 and no issue -> md_err=1 next edge, stays 1 until reset=0.
